// File: rtl/vec_mul_result_stage.sv
`default_nettype none
// ============================================================================
// Module      : vec_mul_result_stage
// Description : Result stage for the Vedic vector multiplier. It applies
//               per-lane sign correction, then selects the lane half.
// Revision    : 1.0 - initial release
// ============================================================================
module vec_mul_result_stage #(
    parameter int DATA_W = 32,
    parameter int PREC_W = 2,
    parameter int OP_W   = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2*DATA_W-1:0]   in_prod_mag,
    input  logic [3:0]            in_neg_lane,
    input  logic [PREC_W-1:0]     in_precision,
    input  logic [OP_W-1:0]       in_op,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     out_result
);

    localparam int                 PROD_W    = 2 * DATA_W;
    localparam logic [PREC_W-1:0]  C_PREC_8  = PREC_W'(0);
    localparam logic [PREC_W-1:0]  C_PREC_16 = PREC_W'(1);
    localparam logic [OP_W-1:0]    C_OP_MUL  = OP_W'(0);

    logic                 r_s1_valid;
    logic [PROD_W-1:0]    r_s1_prod;
    logic [PREC_W-1:0]    r_s1_prec;
    logic [OP_W-1:0]      r_s1_op;

    logic                 w_s2_free;
    logic [PROD_W-1:0]    w_corr8;
    logic [PROD_W-1:0]    w_corr16;
    logic [PROD_W-1:0]    w_corr32;
    logic [PROD_W-1:0]    w_corr;
    logic                 w_hi;
    logic [DATA_W-1:0]    w_sel8;
    logic [DATA_W-1:0]    w_sel16;
    logic [DATA_W-1:0]    w_sel32;
    logic [DATA_W-1:0]    w_sel;

    assign w_s2_free = !out_valid || out_ready;
    assign in_ready  = !r_s1_valid || w_s2_free;

    // Each lane negates independently so a carry can never leak into its neighbour.
    for (genvar i = 0; i < 4; i++) begin : g_neg8
        assign w_corr8[16*i +: 16] = in_neg_lane[i] ? (~in_prod_mag[16*i +: 16] + 16'd1)
                                                    : in_prod_mag[16*i +: 16];
    end

    for (genvar i = 0; i < 2; i++) begin : g_neg16
        assign w_corr16[32*i +: 32] = in_neg_lane[i] ? (~in_prod_mag[32*i +: 32] + 32'd1)
                                                     : in_prod_mag[32*i +: 32];
    end

    assign w_corr32 = in_neg_lane[0] ? (~in_prod_mag + 64'd1) : in_prod_mag;

    always_comb begin
        w_corr = w_corr32;
        if (in_precision == C_PREC_8) begin
            w_corr = w_corr8;
        end else if (in_precision == C_PREC_16) begin
            w_corr = w_corr16;
        end
    end

    assign w_hi = (r_s1_op != C_OP_MUL);

    for (genvar i = 0; i < 4; i++) begin : g_sel8
        assign w_sel8[8*i +: 8] = w_hi ? r_s1_prod[16*i+8 +: 8] : r_s1_prod[16*i +: 8];
    end

    for (genvar i = 0; i < 2; i++) begin : g_sel16
        assign w_sel16[16*i +: 16] = w_hi ? r_s1_prod[32*i+16 +: 16] : r_s1_prod[32*i +: 16];
    end

    assign w_sel32 = w_hi ? r_s1_prod[PROD_W-1:DATA_W] : r_s1_prod[DATA_W-1:0];

    // Code 11 is reserved and falls through to the 32-bit path.
    always_comb begin
        w_sel = w_sel32;
        if (r_s1_prec == C_PREC_8) begin
            w_sel = w_sel8;
        end else if (r_s1_prec == C_PREC_16) begin
            w_sel = w_sel16;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_prod  <= '0;
            r_s1_prec  <= '0;
            r_s1_op    <= '0;
            out_valid  <= 1'b0;
            out_result <= '0;
        end else begin
            if (in_ready) begin
                r_s1_valid <= in_valid;
                if (in_valid) begin
                    r_s1_prod <= w_corr;
                    r_s1_prec <= in_precision;
                    r_s1_op   <= in_op;
                end
            end
            if (w_s2_free) begin
                out_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    out_result <= w_sel;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vec_mul_result_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_vec_mul_result_stage
// Description : Self-checking bench with a lane-arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vec_mul_result_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_prod_mag;
    logic [3:0]  in_neg_lane;
    logic [1:0]  in_precision;
    logic [1:0]  in_op;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;

    int          n_asserts = 0;
    int          n_fails   = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    vec_mul_result_stage dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_prod_mag  (in_prod_mag),
        .in_neg_lane  (in_neg_lane),
        .in_precision (in_precision),
        .in_op        (in_op),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result)
    );

    // Reference: treat each lane as an integer modulo 2^lanewidth, then take a half.
    function automatic logic [31:0] model(input logic [63:0] prod, input logic [3:0] neg,
                                          input logic [1:0] prec, input logic [1:0] op);
        int          lw;
        int          w;
        logic [64:0] modl;
        logic [64:0] mag;
        logic [64:0] p;
        logic [64:0] half;
        logic [31:0] res;
        lw   = (prec == 2'd0) ? 16 : (prec == 2'd1) ? 32 : 64;
        w    = lw / 2;
        modl = 65'd1 << lw;
        res  = '0;
        for (int i = 0; i < 64 / lw; i++) begin
            mag  = ({1'b0, prod} >> (i * lw)) % modl;
            p    = neg[i] ? (modl - mag) % modl : mag;
            half = (op == 2'd0) ? p % (65'd1 << w) : p / (65'd1 << w);
            res  = res | (half[31:0] << (i * w));
        end
        return res;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive, score the handshakes that will fire at the next edge, advance.
    task automatic drive_cycle(input logic v, input logic [63:0] prod, input logic [3:0] neg,
                               input logic [1:0] prec, input logic [1:0] op,
                               input logic ordy, output logic accepted);
        logic [31:0] e;
        in_valid     = v;
        in_prod_mag  = prod;
        in_neg_lane  = neg;
        in_precision = prec;
        in_op        = op;
        out_ready    = ordy;
        #1;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_beat", {32'd0, out_result}, 64'hDEAD_BEEF_0000_0000);
            end else begin
                e = exp_q.pop_front();
                check("scoreboard", {32'd0, out_result}, {32'd0, e});
            end
        end
        accepted = v && in_ready;
        if (accepted) exp_q.push_back(model(prod, neg, prec, op));
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int i = 0; i < n; i++) drive_cycle(1'b0, '0, '0, '0, '0, 1'b1, acc);
    endtask

    task automatic directed(input string tag, input logic [63:0] prod, input logic [3:0] neg,
                            input logic [1:0] prec, input logic [1:0] op, input logic [31:0] exp);
        logic acc;
        drive_cycle(1'b1, prod, neg, prec, op, 1'b1, acc);
        check({tag, "_accept"}, {63'd0, acc}, 64'd1);
        #1 check({tag, "_valid_early"}, {63'd0, out_valid}, 64'd0);
        drive_cycle(1'b0, '0, '0, '0, '0, 1'b1, acc);
        #1;
        check({tag, "_valid"}, {63'd0, out_valid}, 64'd1);
        check(tag, {32'd0, out_result}, {32'd0, exp});
        idle(2);
    endtask

    initial begin
        logic        acc;
        logic [31:0] held;
        int          sent;
        logic [63:0] rp;

        rst_n = 1'b0;
        in_valid = 1'b0; in_prod_mag = '0; in_neg_lane = '0;
        in_precision = '0; in_op = '0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("reset_out_valid", {63'd0, out_valid}, 64'd0);
        check("reset_out_result", {32'd0, out_result}, 64'd0);
        check("reset_in_ready", {63'd0, in_ready}, 64'd1);
        @(negedge clk);

        directed("mul32",   64'h6, 4'b0001, 2'b10, 2'b00, 32'hFFFF_FFFA);
        directed("mulh32",  64'h6, 4'b0001, 2'b10, 2'b01, 32'hFFFF_FFFF);
        directed("mulhu32", 64'h6, 4'b0000, 2'b10, 2'b10, 32'h0000_0000);
        directed("mul32_p11", 64'h6, 4'b0001, 2'b11, 2'b00, 32'hFFFF_FFFA);
        directed("mul8",    64'h0006_0006_0006_0006, 4'b0101, 2'b00, 2'b00, 32'h06FA_06FA);
        directed("mulh8",   64'h0006_0006_0006_0006, 4'b0101, 2'b00, 2'b01, 32'h00FF_00FF);
        directed("mulh16",  64'h0000_0003_0001_0000, 4'b0001, 2'b01, 2'b01, 32'h0000_FFFF);
        directed("mul16",   64'h0000_0003_0001_0000, 4'b0001, 2'b01, 2'b00, 32'h0003_0000);
        directed("neg_zero", 64'h0, 4'b1111, 2'b00, 2'b11, 32'h0000_0000);

        // Back-pressure: four beats offered while the sink stalls for five cycles.
        sent = 0;
        held = '0;
        for (int c = 0; c < 5; c++) begin
            rp = {$urandom, $urandom};
            drive_cycle(1'b1, rp, 4'($urandom), 2'($urandom), 2'($urandom), 1'b0, acc);
            if (acc) sent++;
            #1;
            if (c == 1) begin
                check("bp_accepts_before_full", sent, 2);
                check("bp_in_ready_low", {63'd0, in_ready}, 64'd0);
                held = out_result;
            end
            if (c >= 2) begin
                check("bp_in_ready_held_low", {63'd0, in_ready}, 64'd0);
                check("bp_out_valid_held", {63'd0, out_valid}, 64'd1);
                check("bp_out_result_held", {32'd0, out_result}, {32'd0, held});
            end
        end
        for (int c = 0; c < 20 && sent < 4; c++) begin
            rp = {$urandom, $urandom};
            drive_cycle(1'b1, rp, 4'($urandom), 2'($urandom), 2'($urandom), 1'b1, acc);
            if (acc) sent++;
        end
        check("bp_all_sent", sent, 4);
        idle(4);
        check("bp_drained", exp_q.size(), 0);

        // Reset with two beats in flight.
        drive_cycle(1'b1, 64'h1234, 4'b0001, 2'b10, 2'b00, 1'b0, acc);
        drive_cycle(1'b1, 64'h5678, 4'b0000, 2'b10, 2'b00, 1'b0, acc);
        rst_n = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        #1;
        check("rst_mid_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_mid_out_result", {32'd0, out_result}, 64'd0);
        check("rst_mid_in_ready", {63'd0, in_ready}, 64'd1);
        for (int c = 0; c < 4; c++) begin
            #1 check("rst_no_stale", {63'd0, out_valid}, 64'd0);
            idle(1);
        end

        // Random traffic with random stalls on both sides.
        for (int c = 0; c < 400; c++) begin
            case ($urandom_range(3))
                0: rp = 64'h0;
                1: rp = {48'h0, 16'($urandom)};
                default: rp = {$urandom, $urandom};
            endcase
            drive_cycle(1'($urandom_range(3) != 0), rp, 4'($urandom), 2'($urandom),
                        2'($urandom), 1'($urandom_range(3) != 0), acc);
        end
        for (int c = 0; c < 50 && exp_q.size() != 0; c++) idle(1);
        check("random_drained", exp_q.size(), 0);
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
